// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory pipeline stage: load/store width codes
//   (func3) and the default data-memory size.
//   Optional feature macro used by the stage: MEM_STAGE_RESET_CLEAR_EN
//   (reset clears the data memory when defined).
package mem_stage_pkg;

    localparam int unsigned DEPTH_BYTES_DEFAULT = 1024;

    // Load/store width codes carried on func3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem
//   Byte-addressed little-endian data memory with byte-lane store logic and
//   an asynchronous word read of the naturally aligned word containing addr_i.
//   Configuration macro: MEM_STAGE_RESET_CLEAR_EN -- when defined, rst_ni low
//   clears every byte; otherwise contents start at 0 and survive reset.
// Ports:
//   clk_i    in   clock, stores on rising edge
//   rst_ni   in   asynchronous active-low reset; stores are suppressed while low
//   we_i     in   store strobe
//   func3_i  in   store width (SB/SH/SW; other codes do not write)
//   addr_i   in   byte address, already reduced modulo DEPTH_BYTES
//   wdata_i  in   store data (low byte/half/word used)
//   rdata_o  out  word at addr_i with bits [1:0] forced to 0
module mem_stage_dmem
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           we_i,
    input  logic [2:0]                     func3_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem_q [DEPTH_BYTES] = '{default: 8'h00};
    logic [AW-1:0] base;
    logic [3:0]    be;
    logic [31:0]   lanes;

    // All accesses work on the aligned word; the lane enables pick the bytes.
    assign base = addr_i & ~AW'(3);

    always_comb begin
        be    = '0;
        lanes = '0;
        case (func3_i)
            F3_B: begin
                be    = 4'b0001 << addr_i[1:0];
                lanes = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be    = addr_i[1] ? 4'b1100 : 4'b0011;
                lanes = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                be    = '1;
                lanes = wdata_i;
            end
            default: begin
                be    = '0;
                lanes = '0;
            end
        endcase
        if (!we_i) be = '0;
    end

`ifdef MEM_STAGE_RESET_CLEAR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
        end else begin
            for (int unsigned l = 0; l < 4; l++)
                if (be[l]) mem_q[base | AW'(l)] <= lanes[8*l +: 8];
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int unsigned l = 0; l < 4; l++)
                if (be[l]) mem_q[base | AW'(l)] <= lanes[8*l +: 8];
        end
    end
`endif

    assign rdata_o = {mem_q[base | AW'(3)], mem_q[base | AW'(2)],
                      mem_q[base | AW'(1)], mem_q[base]};

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory pipeline stage: registers the EX_ control/data fields into MEM_
//   outputs (1-cycle latency), performs stores into mem_stage_dmem and
//   produces the registered, width-extended load result.
//   Configuration macro: MEM_STAGE_RESET_CLEAR_EN (reset clears memory).
// Ports:
//   CLK                 in   clock
//   RST                 in   asynchronous active-low reset
//   EX_FUNC3            in   load/store width code
//   EX_WRITE_ENABLE     in   register-file write enable (passed through)
//   EX_DATA_MEM_SELECT  in   writeback mux select (passed through)
//   EX_MEM_WRITE        in   store strobe
//   EX_MEM_READ         in   load strobe
//   EX_JAL_SELECTED     in   byte address / writeback value
//   EX_READ_DATA2       in   store data
//   EX_RD               in   destination register
//   MEM_*               out  registered copies of the EX_ fields
//   MEM_DATA_OUT        out  registered load result (0 when no load)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  EX_FUNC3,
    input  logic        EX_WRITE_ENABLE,
    input  logic        EX_DATA_MEM_SELECT,
    input  logic        EX_MEM_WRITE,
    input  logic        EX_MEM_READ,
    input  logic [31:0] EX_JAL_SELECTED,
    input  logic [31:0] EX_READ_DATA2,
    input  logic [4:0]  EX_RD,
    output logic [2:0]  MEM_FUNC3,
    output logic        MEM_WRITE_ENABLE,
    output logic        MEM_DATA_MEM_SELECT,
    output logic [31:0] MEM_JAL_SELECTED,
    output logic [4:0]  MEM_RD,
    output logic [31:0] MEM_DATA_OUT
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    logic [31:0] rword;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] data_d, data_q;
    logic [2:0]  func3_q;
    logic        we_q, sel_q;
    logic [31:0] jal_q;
    logic [4:0]  rd_q;

    mem_stage_dmem #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_dmem (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .we_i    (EX_MEM_WRITE),
        .func3_i (EX_FUNC3),
        .addr_i  (EX_JAL_SELECTED[AW-1:0]),
        .wdata_i (EX_READ_DATA2),
        .rdata_o (rword)
    );

    // The read is combinational and sampled at the same edge as any store,
    // so a simultaneous load sees the pre-store contents.
    always_comb begin
        byte_v = 8'(rword >> {EX_JAL_SELECTED[1:0], 3'b000});
        half_v = EX_JAL_SELECTED[1] ? rword[31:16] : rword[15:0];
        data_d = '0;
        if (EX_MEM_READ) begin
            case (EX_FUNC3)
                F3_B:    data_d = {{24{byte_v[7]}}, byte_v};
                F3_H:    data_d = {{16{half_v[15]}}, half_v};
                F3_W:    data_d = rword;
                F3_BU:   data_d = {24'h0, byte_v};
                F3_HU:   data_d = {16'h0, half_v};
                default: data_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            func3_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            jal_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            func3_q <= EX_FUNC3;
            we_q    <= EX_WRITE_ENABLE;
            sel_q   <= EX_DATA_MEM_SELECT;
            jal_q   <= EX_JAL_SELECTED;
            rd_q    <= EX_RD;
            data_q  <= data_d;
        end
    end

    assign MEM_FUNC3           = func3_q;
    assign MEM_WRITE_ENABLE    = we_q;
    assign MEM_DATA_MEM_SELECT = sel_q;
    assign MEM_JAL_SELECTED    = jal_q;
    assign MEM_RD              = rd_q;
    assign MEM_DATA_OUT        = data_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [2:0]  EX_FUNC3 = '0;
    logic        EX_WRITE_ENABLE = 1'b0;
    logic        EX_DATA_MEM_SELECT = 1'b0;
    logic        EX_MEM_WRITE = 1'b0;
    logic        EX_MEM_READ = 1'b0;
    logic [31:0] EX_JAL_SELECTED = '0;
    logic [31:0] EX_READ_DATA2 = '0;
    logic [4:0]  EX_RD = '0;
    logic [2:0]  MEM_FUNC3;
    logic        MEM_WRITE_ENABLE;
    logic        MEM_DATA_MEM_SELECT;
    logic [31:0] MEM_JAL_SELECTED;
    logic [4:0]  MEM_RD;
    logic [31:0] MEM_DATA_OUT;

    mem_stage #(.DEPTH_BYTES(1024)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .EX_FUNC3            (EX_FUNC3),
        .EX_WRITE_ENABLE     (EX_WRITE_ENABLE),
        .EX_DATA_MEM_SELECT  (EX_DATA_MEM_SELECT),
        .EX_MEM_WRITE        (EX_MEM_WRITE),
        .EX_MEM_READ         (EX_MEM_READ),
        .EX_JAL_SELECTED     (EX_JAL_SELECTED),
        .EX_READ_DATA2       (EX_READ_DATA2),
        .EX_RD               (EX_RD),
        .MEM_FUNC3           (MEM_FUNC3),
        .MEM_WRITE_ENABLE    (MEM_WRITE_ENABLE),
        .MEM_DATA_MEM_SELECT (MEM_DATA_MEM_SELECT),
        .MEM_JAL_SELECTED    (MEM_JAL_SELECTED),
        .MEM_RD              (MEM_RD),
        .MEM_DATA_OUT        (MEM_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        we;
        logic        sel;
        logic [31:0] jal;
        logic [4:0]  rd;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned tag     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".data"}, MEM_DATA_OUT, 32'h0);
        chk({nm, ".f3"},   32'(MEM_FUNC3), 32'h0);
        chk({nm, ".we"},   32'(MEM_WRITE_ENABLE), 32'h0);
        chk({nm, ".sel"},  32'(MEM_DATA_MEM_SELECT), 32'h0);
        chk({nm, ".jal"},  MEM_JAL_SELECTED, 32'h0);
        chk({nm, ".rd"},   32'(MEM_RD), 32'h0);
    endtask

    // Drive one vector for one edge; pass-through expectations come from the
    // driven values, the load result from the vector's expected field.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        tag++;
        EX_FUNC3           = v.f3;
        EX_MEM_WRITE       = v.wr;
        EX_MEM_READ        = v.rd_en;
        EX_JAL_SELECTED    = v.addr;
        EX_READ_DATA2      = v.wdata;
        EX_RD              = 5'(tag);
        EX_WRITE_ENABLE    = tag[0];
        EX_DATA_MEM_SELECT = tag[1];
        e.name = v.name; e.data = v.exp; e.f3 = v.f3; e.we = tag[0];
        e.sel = tag[1]; e.jal = v.addr; e.rd = 5'(tag);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        if (sbq.size() == 0) begin
            chk({v.name, ".queue"}, 32'h0, 32'h1);
        end else begin
            g = sbq.pop_front();
            chk({g.name, ".data"}, MEM_DATA_OUT, g.data);
            chk({g.name, ".f3"},   32'(MEM_FUNC3), 32'(g.f3));
            chk({g.name, ".we"},   32'(MEM_WRITE_ENABLE), 32'(g.we));
            chk({g.name, ".sel"},  32'(MEM_DATA_MEM_SELECT), 32'(g.sel));
            chk({g.name, ".jal"},  MEM_JAL_SELECTED, g.jal);
            chk({g.name, ".rd"},   32'(MEM_RD), 32'(g.rd));
        end
    endtask

    function automatic vec_t mk(input string n, input logic w, input logic r, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] x);
        vec_t v;
        v.name = n; v.wr = w; v.rd_en = r; v.f3 = f; v.addr = a; v.wdata = d; v.exp = x;
        return v;
    endfunction

    initial begin
        vec_t        v;
        logic [31:0] exp18;

        vecs.push_back(mk("sw_04",      1, 0, F3_W,   32'h04, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("lw_04",      0, 1, F3_W,   32'h04, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("sw_08",      1, 0, F3_W,   32'h08, 32'hCAFEBABE, 32'h0));
        vecs.push_back(mk("lh_08",      0, 1, F3_H,   32'h08, 32'h0,        32'hFFFFBABE));
        vecs.push_back(mk("lhu_08",     0, 1, F3_HU,  32'h08, 32'h0,        32'h0000BABE));
        vecs.push_back(mk("sh_0c",      1, 0, F3_H,   32'h0C, 32'h00C0BEEF, 32'h0));
        vecs.push_back(mk("lh_0c",      0, 1, F3_H,   32'h0C, 32'h0,        32'hFFFFBEEF));
        vecs.push_back(mk("lw_0c",      0, 1, F3_W,   32'h0C, 32'h0,        32'h0000BEEF));
        vecs.push_back(mk("sb_10",      1, 0, F3_B,   32'h10, 32'h000000EF, 32'h0));
        vecs.push_back(mk("lb_10",      0, 1, F3_B,   32'h10, 32'h0,        32'hFFFFFFEF));
        vecs.push_back(mk("lbu_10",     0, 1, F3_BU,  32'h10, 32'h0,        32'h000000EF));
        vecs.push_back(mk("lh_09_algn", 0, 1, F3_H,   32'h09, 32'h0,        32'hFFFFBABE));
        vecs.push_back(mk("lw_0b_algn", 0, 1, F3_W,   32'h0B, 32'h0,        32'hCAFEBABE));
        vecs.push_back(mk("lb_0b",      0, 1, F3_B,   32'h0B, 32'h0,        32'hFFFFFFCA));
        vecs.push_back(mk("lhu_0a",     0, 1, F3_HU,  32'h0A, 32'h0,        32'h0000CAFE));
        vecs.push_back(mk("ld_bad_f3",  0, 1, 3'b011, 32'h08, 32'h0,        32'h0));
        vecs.push_back(mk("st_bad_f3",  1, 0, 3'b011, 32'h14, 32'h12345678, 32'h0));
        vecs.push_back(mk("lw_14",      0, 1, F3_W,   32'h14, 32'h0,        32'h0));
        vecs.push_back(mk("sw_wrap",    1, 0, F3_W,   32'h80000420, 32'h11223344, 32'h0));
        vecs.push_back(mk("lw_20",      0, 1, F3_W,   32'h20, 32'h0,        32'h11223344));
        vecs.push_back(mk("sb_22",      1, 0, F3_B,   32'h22, 32'h000000AB, 32'h0));
        vecs.push_back(mk("lw_20_sb",   0, 1, F3_W,   32'h20, 32'h0,        32'h11AB3344));
        vecs.push_back(mk("sh_23",      1, 0, F3_H,   32'h23, 32'h00009999, 32'h0));
        vecs.push_back(mk("lw_20_sh",   0, 1, F3_W,   32'h20, 32'h0,        32'h99993344));
        vecs.push_back(mk("rw_same_04", 1, 1, F3_W,   32'h04, 32'h55667788, 32'hDEADBEEF));
        vecs.push_back(mk("lw_04_new",  0, 1, F3_W,   32'h04, 32'h0,        32'h55667788));
        vecs.push_back(mk("no_read",    0, 0, F3_W,   32'h04, 32'h0,        32'h0));

        // Reset state
        #2;
        chk_all_zero("reset_init");
        @(negedge CLK);
        RST = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-stream reset: outputs clear asynchronously, stores are blocked.
        apply(mk("sw_18", 1, 0, F3_W, 32'h18, 32'hAABBCCDD, 32'h0));
        apply(mk("lw_18", 0, 1, F3_W, 32'h18, 32'h0,        32'hAABBCCDD));
        RST = 1'b0;
        #1;
        chk_all_zero("rst_async");
        EX_MEM_WRITE    = 1'b1;
        EX_MEM_READ     = 1'b1;
        EX_FUNC3        = F3_W;
        EX_JAL_SELECTED = 32'h18;
        EX_READ_DATA2   = 32'hFFFFFFFF;
        EX_RD           = 5'd7;
        @(posedge CLK);
        #1;
        chk_all_zero("rst_held");
        #2;
        RST = 1'b1;
`ifdef MEM_STAGE_RESET_CLEAR_EN
        exp18 = 32'h0;
`else
        exp18 = 32'hAABBCCDD;
`endif
        v = mk("lw_18_post", 0, 1, F3_W, 32'h18, 32'h0, exp18);
        apply(v);
        apply(mk("lw_04_post", 0, 1, F3_W, 32'h04, 32'h0,
`ifdef MEM_STAGE_RESET_CLEAR_EN
                 32'h0
`else
                 32'h55667788
`endif
                 ));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named CLK and RST.
REQ-002 Parameter DEPTH_BYTES, default 1024, SHALL set the data memory size in bytes (power of two, at least 4).
REQ-003 CLK  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 RST  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 EX_FUNC3  in  3  SHALL carry the load/store width code.
REQ-006 EX_WRITE_ENABLE  in  1  SHALL be the register-file write enable, passed through.
REQ-007 EX_DATA_MEM_SELECT  in  1  SHALL be the writeback-mux select, passed through.
REQ-008 EX_MEM_WRITE  in  1  SHALL be the store strobe.
REQ-009 EX_MEM_READ  in  1  SHALL be the load strobe.
REQ-010 EX_JAL_SELECTED  in  32  SHALL be the memory byte address and the writeback value.
REQ-011 EX_READ_DATA2  in  32  SHALL be the store data.
REQ-012 EX_RD  in  5  SHALL be the destination register index.
REQ-013 Outputs MEM_FUNC3 (3), MEM_WRITE_ENABLE (1), MEM_DATA_MEM_SELECT (1), MEM_JAL_SELECTED (32) and MEM_RD (5) SHALL be registered copies of the matching EX_ inputs.
REQ-014 MEM_DATA_OUT  out  32  SHALL be the registered load result.

Function
REQ-015 Each rising CLK edge SHALL capture all EX_ pass-through inputs into their MEM_ outputs, giving 1-cycle latency.
REQ-016 Memory SHALL be little-endian and byte-addressed by EX_JAL_SELECTED modulo DEPTH_BYTES, so higher address bits wrap.
REQ-017 When EX_MEM_WRITE=1 at a rising edge, the store SHALL be selected by EX_FUNC3 as follows:
- 000 (SB): write byte [7:0].
- 001 (SH): write half [15:0] at the address with bit 0 forced to 0.
- 010 (SW): write the full word at the address with bits [1:0] forced to 0.
- Any other code: no write.
REQ-018 When EX_MEM_READ=1 at a rising edge, MEM_DATA_OUT SHALL load the value selected by EX_FUNC3 as follows:
- 000 (LB): sign-extended byte.
- 001 (LH): sign-extended half.
- 010 (LW): word.
- 100 (LBU): zero-extended byte.
- 101 (LHU): zero-extended half.
- Any other code: 0.
REQ-019 Load alignment SHALL match the store rules: LH/LHU use address bit 0 forced to 0, and LW uses bits [1:0] forced to 0.
REQ-020 When EX_MEM_READ=0 at a rising edge, MEM_DATA_OUT SHALL become 0.
REQ-021 A store at edge N SHALL be visible to a load at edge N+1 or later.
REQ-022 When EX_MEM_READ and EX_MEM_WRITE are both 1 on one edge, the load SHALL return the pre-store contents and the store SHALL still complete.
REQ-023 Reads SHALL have no side effects.

Reset
REQ-024 While RST=0, every MEM_ output SHALL be 0, asynchronously.
REQ-025 While RST=0, stores SHALL be suppressed.
REQ-026 Memory contents SHALL be retained across reset unless REQ-028 applies.
REQ-027 The first rising edge after RST deasserts SHALL operate normally.

Configuration
REQ-028 With macro MEM_STAGE_RESET_CLEAR_EN defined, asserting RST SHALL clear every memory byte to 0.
REQ-029 Without MEM_STAGE_RESET_CLEAR_EN, memory SHALL start as 0 at simulation time 0 and SHALL NOT be cleared by reset.

Structure
REQ-030 Package mem_stage_pkg SHALL hold the func3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and the DEPTH_BYTES default.
REQ-031 One sub-module, mem_stage_dmem, SHALL contain the byte array and byte-lane write logic.
REQ-032 The pipeline registers and the load extension logic SHALL live in mem_stage.

Verification
REQ-033 SW 0xDEADBEEF at 0x04, then LW at 0x04 -> MEM_DATA_OUT=0xDEADBEEF one edge after the load.
REQ-034 SW 0xCAFEBABE at 0x08, then LH at 0x08 -> 0xFFFFBABE, and LHU at 0x08 -> 0x0000BABE.
REQ-035 SH 0x00C0BEEF at 0x0C, then LH at 0x0C -> 0xFFFFBEEF, and LW at 0x0C -> 0x0000BEEF.
REQ-036 SB 0x000000EF at 0x10, then LB -> 0xFFFFFFEF, and LBU -> 0x000000EF.
REQ-037 Store and load at one address on one edge -> old data returned, new data returned on the next load.
REQ-038 Pulse RST low mid-stream -> all MEM_ outputs 0 immediately, and a prior SW at 0x18 is still read back unless MEM_STAGE_RESET_CLEAR_EN is defined.
